// File: rtl/fifo_uart_tx_if.sv
`default_nettype none
// ============================================================================
// fifo_uart_tx_if : FIFO-side and serial-side signals of the UART transmitter
// Rev 1.0
// ============================================================================
interface fifo_uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  tx_en;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_rd_en;
  logic                  tx;
  logic                  tx_busy;
  logic                  tx_done;

  modport master (
    output tx_en, fifo_empty, fifo_dout,
    input  fifo_rd_en, tx, tx_busy, tx_done
  );

  modport slave (
    input  tx_en, fifo_empty, fifo_dout,
    output fifo_rd_en, tx, tx_busy, tx_done
  );
endinterface
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// fifo_uart_tx : pops bytes from a show-ahead FIFO and sends them as 8N1-style
//                UART frames (start, LSB-first data, 1 or 2 stop bits).
// Rev 1.0
// ============================================================================
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  fifo_uart_tx_if.slave     bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BAUD_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      baud;
  logic [BIT_W-1:0]      bit_idx;
  logic                  stop_idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  tx_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  pop;
  logic                  baud_wrap;
  logic [DATA_WIDTH-1:0] shifted;

  // Pop is decoded combinationally so the byte is captured on the very next edge.
  assign pop       = (state == IDLE) && bus.tx_en && !bus.fifo_empty;
  assign baud_wrap = (baud == BAUD_LAST);
  assign shifted   = shreg >> 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            shreg  <= bus.fifo_dout;
            state  <= START;
            baud   <= '0;
            tx_q   <= 1'b0;
            busy_q <= 1'b1;
          end
        end
        START: begin
          if (baud_wrap) begin
            state   <= DATA;
            baud    <= '0;
            bit_idx <= '0;
            tx_q    <= shreg[0];
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (baud_wrap) begin
            baud  <= '0;
            shreg <= shifted;
            if (bit_idx == BIT_LAST) begin
              state    <= STOP;
              stop_idx <= 1'b0;
              tx_q     <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx_q    <= shifted[0];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          // Registered done is raised one cycle early so it lands on the final stop cycle.
          if ((stop_idx == STOP_LAST) && (baud == BAUD_PRE)) begin
            done_q <= 1'b1;
          end
          if (baud_wrap) begin
            baud <= '0;
            if (stop_idx == STOP_LAST) begin
              state    <= IDLE;
              stop_idx <= 1'b0;
              busy_q   <= 1'b0;
            end else begin
              stop_idx <= 1'b1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.fifo_rd_en = pop;
  assign bus.tx         = tx_q;
  assign bus.tx_busy    = busy_q;
  assign bus.tx_done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// tb_fifo_uart_tx : randomized scoreboard bench; expected frames are queued at
//                   push time and a negedge monitor checks every line cycle.
// Rev 1.0
// ============================================================================
module tb_fifo_uart_tx;

  localparam int DW     = 8;
  localparam int CPB    = 4;
  localparam int SB     = 1;
  localparam int FRAME  = (1 + DW + SB) * CPB;
  localparam int PERIOD = FRAME + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_uart_tx_if #(.DATA_WIDTH(DW)) bus ();

  fifo_uart_tx #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (SB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  int         pop_log[$];

  int         total     = 0;
  int         passed    = 0;
  int         cyc       = 0;
  int         frame_cyc = 0;
  logic [7:0] cur       = 8'h00;
  bit         pop_pending = 1'b0;
  int         pushed    = 0;
  int         n         = 0;
  int         d         = 0;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] req);
    total++;
    if (ok) passed++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
  endtask

  // Line level k cycles into a frame, derived from the frame layout.
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    int slot;
    slot = (k - 1) / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= DW) return b[slot-1];
    return 1'b1;
  endfunction

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic wait_idle(input int maxc, input string name);
    int k;
    k = 0;
    while (!(fq.size() == 0 && exp_q.size() == 0 && frame_cyc == 0) && k < maxc) begin
      @(posedge clk);
      k++;
    end
    check(k < maxc, name, k, maxc);
  endtask

  // Upstream FIFO model: show-ahead, flags refreshed just after each edge.
  initial begin
    bus.tx_en      = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_dout  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (pop_pending && fq.size() > 0) void'(fq.pop_front());
      bus.fifo_empty = (fq.size() == 0);
      bus.fifo_dout  = (fq.size() > 0) ? fq[0] : 8'($urandom);
    end
  end

  always @(negedge clk) begin : monitor
    logic [3:0] act;
    logic [3:0] expv;
    cyc++;
    act         = {bus.tx, bus.tx_busy, bus.tx_done, bus.fifo_rd_en};
    pop_pending = bus.fifo_rd_en;
    if (!rst_n) begin
      frame_cyc = 0;
      check(act == 4'b1000, "reset_outputs", act, 4'b1000);
    end else if (frame_cyc > 0) begin
      expv = {exp_bit(cur, frame_cyc), 1'b1, (frame_cyc == FRAME), 1'b0};
      check(act == expv, "frame_cycle", act, expv);
      if (frame_cyc == FRAME) frame_cyc = 0;
      else frame_cyc++;
    end else begin
      expv = {1'b1, 1'b0, 1'b0, (bus.tx_en && !bus.fifo_empty)};
      check(act == expv, "idle_cycle", act, expv);
      if (bus.fifo_rd_en) begin
        pop_log.push_back(cyc);
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_pop", 1, 0);
        end else begin
          cur       = exp_q.pop_front();
          frame_cyc = 1;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check({bus.tx, bus.tx_busy, bus.tx_done, bus.fifo_rd_en} == 4'b1000, "reset_state",
          {bus.tx, bus.tx_busy, bus.tx_done, bus.fifo_rd_en}, 4'b1000);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Single byte
    @(posedge clk); #2;
    bus.tx_en = 1'b1;
    pop_log.delete();
    push(8'hA5);
    wait_idle(200, "single_timeout");
    check(pop_log.size() == 1, "single_pop_count", pop_log.size(), 1);

    // Back-to-back frames
    @(posedge clk); #2;
    pop_log.delete();
    push(8'h00);
    push(8'hFF);
    wait_idle(300, "b2b_timeout");
    check(pop_log.size() == 2, "b2b_pop_count", pop_log.size(), 2);
    d = (pop_log.size() == 2) ? (pop_log[1] - pop_log[0]) : -1;
    check(d == PERIOD, "b2b_spacing", d, PERIOD);

    // Empty FIFO
    pop_log.delete();
    repeat (100) @(posedge clk);
    check(pop_log.size() == 0, "empty_no_pop", pop_log.size(), 0);

    // tx_en gating
    @(posedge clk); #2;
    bus.tx_en = 1'b0;
    push(8'h3C);
    repeat (20) @(posedge clk);
    check(pop_log.size() == 0, "gated_no_pop", pop_log.size(), 0);
    #2 bus.tx_en = 1'b1;
    @(negedge clk); #1;
    check(pop_log.size() == 1, "gate_release_pop", pop_log.size(), 1);
    repeat (12) @(posedge clk);
    #2 bus.tx_en = 1'b0;
    wait_idle(100, "gated_frame_timeout");
    check(pop_log.size() == 1, "gated_single_pop", pop_log.size(), 1);

    // Randomized traffic with tx_en toggling
    bus.tx_en = 1'b1;
    pushed    = 0;
    repeat (800) begin
      @(posedge clk); #2;
      if (pushed < 20 && $urandom_range(0, 7) == 0) begin
        push(8'($urandom));
        pushed++;
      end
      bus.tx_en = ($urandom_range(0, 3) != 0);
    end
    bus.tx_en = 1'b1;
    while (pushed < 20) begin
      push(8'($urandom));
      pushed++;
    end
    wait_idle(2000, "random_timeout");

    // Reset during bit 3 of 0x81
    @(posedge clk); #2;
    pop_log.delete();
    push(8'h81);
    n = 0;
    while (pop_log.size() == 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check(pop_log.size() == 1, "rst_test_pop", pop_log.size(), 1);
    repeat (17) @(posedge clk);
    #1;
    check(bus.tx == 1'b0, "bit3_level_before_reset", bus.tx, 0);
    #1 rst_n = 1'b0;
    #1;
    check(bus.tx == 1'b1, "async_reset_tx", bus.tx, 1);
    check(bus.tx_busy == 1'b0, "async_reset_busy", bus.tx_busy, 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    pop_log.delete();
    repeat (50) @(posedge clk);
    check(pop_log.size() == 0, "post_reset_no_pop", pop_log.size(), 0);
    check(fq.size() == 0 && exp_q.size() == 0, "post_reset_queues_empty",
          fq.size() + exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
